// File: rtl/mips_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_muldiv : iterative 32-bit mult/multu/div/divu unit with HI/LO regs  |
// | Optional single-cycle mult/multu: MIPS_MULDIV_FAST_MULT_EN   Rev 1.0     |
// +--------------------------------------------------------------------------+
module mips_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] in1_i,
  input  logic [31:0] in2_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q,    op_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic [63:0] acc_q,   acc_d;
  logic [31:0] opb_q,   opb_d;
  logic        neg_q,   neg_d;
  logic        rneg_q,  rneg_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic        done_q,  done_d;

  // Operand conditioning for the iterative path
  logic        w_signed;
  logic        w_s1;
  logic        w_s2;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;

  assign w_signed = ~op_i[0];
  assign w_s1     = w_signed & in1_i[31];
  assign w_s2     = w_signed & in2_i[31];
  assign w_mag1   = w_s1 ? -in1_i : in1_i;
  assign w_mag2   = w_s2 ? -in2_i : in2_i;

  // Multiply step: acc = {product_hi, multiplier}; add then shift right
  logic [32:0] w_madd;
  logic [63:0] w_mstep;

  assign w_madd  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign w_mstep = {w_madd, acc_q[31:1]};

  // Restoring divide step on {rem, quot}; shifted remainder may reach 33 bits
  logic        w_dge;
  logic [31:0] w_dsub;
  logic [63:0] w_dstep;

  assign w_dge   = (acc_q[63:31] >= {1'b0, opb_q});
  assign w_dsub  = acc_q[62:31] - opb_q;
  assign w_dstep = w_dge ? {w_dsub, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

  // Sign correction; a zero divisor leaves rem=|dividend|, restored to in1 here
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_prod = neg_q  ? -acc_q : acc_q;
  assign w_quot = neg_q  ? -acc_q[31:0] : acc_q[31:0];
  assign w_rem  = rneg_q ? -acc_q[63:32] : acc_q[63:32];

  logic        w_fast;
  logic [63:0] w_fprod;

`ifdef MIPS_MULDIV_FAST_MULT_EN
  logic signed [63:0] w_fa;
  logic signed [63:0] w_fb;

  assign w_fa    = {{32{w_signed & in1_i[31]}}, in1_i};
  assign w_fb    = {{32{w_signed & in2_i[31]}}, in2_i};
  assign w_fprod = w_fa * w_fb;
  assign w_fast  = ~op_i[1];
`else
  assign w_fprod = 64'd0;
  assign w_fast  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (w_fast) begin
            hi_d   = w_fprod[63:32];
            lo_d   = w_fprod[31:0];
            done_d = 1'b1;
          end else begin
            op_d    = op_i;
            cnt_d   = 5'd31;
            acc_d   = {32'd0, w_mag1};
            opb_d   = w_mag2;
            neg_d   = w_s1 ^ w_s2;
            rneg_d  = w_s1;
            state_d = ST_RUN;
          end
        end else begin
          if (hi_we_i) hi_d = in1_i;
          if (lo_we_i) lo_d = in1_i;
        end
      end
      ST_RUN: begin
        acc_d = op_q[1] ? w_dstep : w_mstep;
        if (cnt_q == 5'd0) state_d = ST_FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      ST_FIX: begin
        if (op_q[1]) begin
          hi_d = w_rem;
          lo_d = (opb_q == 32'd0) ? 32'hFFFF_FFFF : w_quot;
        end else begin
          hi_d = w_prod[63:32];
          lo_d = w_prod[31:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 2'd0;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      opb_q   <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_muldiv : self-checking bench for mips_muldiv        Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_mips_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

`ifdef MIPS_MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  mips_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .op_i    (op),
    .in1_i   (in1),
    .in2_i   (in2),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  // Reference: {hi, lo} from plain MIPS arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    logic [31:0] q;
    logic [31:0] r;
    case (o)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'd1: begin
        u = {32'd0, a} * {32'd0, b};
        return u;
      end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
    return (FAST && !o[1]) ? 0 : 33;
  endfunction

  // Launch one op, scramble operands after acceptance, observe completion
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic wh, input logic wl,
                       output int k, output logic busy0, output logic busy_d,
                       output logic [31:0] rh, output logic [31:0] rl, output logic done_after);
    @(negedge clk);
    start = 1'b1; op = o; in1 = a; in2 = b; hi_we = wh; lo_we = wl;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom_range(3)); in1 = $urandom; in2 = $urandom;
    busy0 = busy;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    busy_d = busy;
    rh = hi;
    rl = lo;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'd0; in1 = 32'd0; in2 = 32'd0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else passed++;
    total++; if (hi !== 32'd0) $display("FAIL reset hi: got %h want 0", hi); else passed++;
    total++; if (lo !== 32'd0) $display("FAIL reset lo: got %h want 0", lo); else passed++;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [5];
    logic [31:0] t_a [5];
    logic [31:0] t_b [5];
    logic [31:0] t_h [5];
    logic [31:0] t_l [5];
    int k; logic b0, bd, da; logic [31:0] rh, rl;
    t_op = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    t_a  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
    t_b  = '{32'd5,         32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'd0};
    t_h  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,         32'h0000_0064};
    t_l  = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 1'b0, 1'b0, k, b0, bd, rh, rl, da);
      total++; if (rh !== t_h[i]) $display("FAIL dir%0d hi: got %h want %h", i, rh, t_h[i]); else passed++;
      total++; if (rl !== t_l[i]) $display("FAIL dir%0d lo: got %h want %h", i, rl, t_l[i]); else passed++;
      total++; if (k !== exp_lat(t_op[i])) $display("FAIL dir%0d latency: got %0d want %0d", i, k, exp_lat(t_op[i])); else passed++;
      total++; if (b0 !== (exp_lat(t_op[i]) != 0)) $display("FAIL dir%0d busy after accept: got %b want %b", i, b0, exp_lat(t_op[i]) != 0); else passed++;
      total++; if (bd !== 1'b0) $display("FAIL dir%0d busy at done: got %b want 0", i, bd); else passed++;
      total++; if (da !== 1'b0) $display("FAIL dir%0d done pulse width: got %b want 0", i, da); else passed++;
    end
  endtask

  task automatic test_random();
    logic [1:0] o; logic [31:0] a, b; logic [63:0] m;
    int k; logic b0, bd, da; logic [31:0] rh, rl;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(3)); a = $urandom; b = $urandom;
      case ($urandom_range(7))
        0: b = 32'd0;
        1: b = $urandom_range(15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = $urandom_range(100);
        default: ;
      endcase
      m = model(o, a, b);
      do_op(o, a, b, 1'b0, 1'b0, k, b0, bd, rh, rl, da);
      total++; if (rh !== m[63:32]) $display("FAIL rand%0d op%0d %h,%h hi: got %h want %h", i, o, a, b, rh, m[63:32]); else passed++;
      total++; if (rl !== m[31:0]) $display("FAIL rand%0d op%0d %h,%h lo: got %h want %h", i, o, a, b, rl, m[31:0]); else passed++;
      total++; if (k !== exp_lat(o)) $display("FAIL rand%0d latency: got %0d want %0d", i, k, exp_lat(o)); else passed++;
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] h0;
    int k; logic b0, bd, da; logic [31:0] rh, rl;
    h0 = hi;
    @(negedge clk);
    lo_we = 1'b1; in1 = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    total++; if (lo !== 32'h0000_1234) $display("FAIL mtlo lo: got %h want 00001234", lo); else passed++;
    total++; if (hi !== h0) $display("FAIL mtlo hi disturbed: got %h want %h", hi, h0); else passed++;
    total++; if (done !== 1'b0) $display("FAIL mtlo done: got %b want 0", done); else passed++;
    hi_we = 1'b1; in1 = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0;
    total++; if (hi !== 32'hCAFE_F00D) $display("FAIL mthi hi: got %h want cafef00d", hi); else passed++;
    do_op(2'd0, 32'd2, 32'd3, 1'b1, 1'b1, k, b0, bd, rh, rl, da);
    total++; if (rl !== 32'd6) $display("FAIL start-vs-strobe lo: got %h want 6", rl); else passed++;
    total++; if (rh !== 32'd0) $display("FAIL start-vs-strobe hi: got %h want 0", rh); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2; logic [63:0] m1, m2;
    int k;
    a1 = $urandom; b1 = $urandom_range(1000) + 1; a2 = $urandom; b2 = $urandom;
    m1 = model(2'd3, a1, b1);
    m2 = model(2'd2, a2, b2);
    @(negedge clk);
    start = 1'b1; op = 2'd3; in1 = a1; in2 = b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    total++; if (k !== 33) $display("FAIL b2b first latency: got %0d want 33", k); else passed++;
    total++; if ({hi, lo} !== m1) $display("FAIL b2b first result: got %h want %h", {hi, lo}, m1); else passed++;
    start = 1'b1; op = 2'd2; in1 = a2; in2 = b2;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b second accept busy: got %b want 1", busy); else passed++;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 10) begin
        start = 1'b1; op = 2'd1; in1 = $urandom; in2 = $urandom; hi_we = 1'b1; lo_we = 1'b1;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
    end
    total++; if (k !== 33) $display("FAIL b2b second latency: got %0d want 33", k); else passed++;
    total++; if ({hi, lo} !== m2) $display("FAIL b2b second result: got %h want %h", {hi, lo}, m2); else passed++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int dones;
    int k; logic b0, bd, da; logic [31:0] rh, rl;
    @(negedge clk);
    hi_we = 1'b1; in1 = 32'h5555_AAAA;
    @(negedge clk);
    hi_we = 1'b0;
    start = 1'b1; op = 2'd3; in1 = 32'd10; in2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (c == 5) begin
        start = 1'b1; op = 2'd0; in1 = 32'h0000_DEAD; in2 = 32'd7; hi_we = 1'b1;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
      if (c == 5) begin
        total++; if (hi !== 32'h5555_AAAA) $display("FAIL abort strobe while busy: got %h want 5555aaaa", hi); else passed++;
      end
    end
    total++; if (busy !== 1'b1) $display("FAIL abort busy before reset: got %b want 1", busy); else passed++;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort busy: got %b want 0", busy); else passed++;
    total++; if (hi !== 32'd0) $display("FAIL abort hi: got %h want 0", hi); else passed++;
    total++; if (lo !== 32'd0) $display("FAIL abort lo: got %h want 0", lo); else passed++;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      if (done === 1'b1) dones++;
    end
    total++; if (dones !== 0) $display("FAIL abort spurious done: got %0d want 0", dones); else passed++;
    do_op(2'd3, 32'd10, 32'd3, 1'b0, 1'b0, k, b0, bd, rh, rl, da);
    total++; if ({rh, rl} !== {32'd1, 32'd3}) $display("FAIL post-abort divu: got %h want %h", {rh, rl}, {32'd1, 32'd3}); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mthi_mtlo();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative 32-bit multiply/divide unit for the MIPS execute stage, fed the same operand pair as the ALU and sitting beside it ahead of the writeback mux. It implements mult/multu/div/divu into dedicated HI/LO registers, plus mthi/mtlo writes. The datapath is shift-add/restoring, one bit per cycle. Results are read by mfhi/mflo through the `hi`/`lo` outputs.

## Interface
- No parameters; width fixed at 32.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: launch operation; sampled only when `busy`=0.
- `op` input 2: 00 mult, 01 multu, 10 div, 11 divu.
- `in1` input 32: rs operand (multiplicand / dividend).
- `in2` input 32: rt operand (multiplier / divisor).
- `hi_we` input 1: mthi strobe, loads `in1` into HI.
- `lo_we` input 1: mtlo strobe, loads `in1` into LO.
- `busy` output 1: operation in flight; upstream stalls on it.
- `done` output 1: one-cycle pulse, HI/LO updated this cycle.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States: IDLE, RUN, FIX. `busy` = (state != IDLE).
- IDLE + `start`:
  - Latch `op`.
  - Latch operand magnitudes: absolute values for signed ops, raw values for unsigned ops.
  - Latch result sign bits.
  - Set count = 31 and go to RUN.
- RUN, one step per cycle:
  - mult: conditional add of the multiplicand into a 64-bit accumulator, then shift right.
  - div: restoring subtract-and-shift on a 64-bit {rem, quot} register.
  - When count == 0, go to FIX; otherwise decrement count.
- FIX:
  - Apply sign correction. Product is negated if sign(in1) ^ sign(in2) for mult.
  - For div, the quotient is negated if the signs differ, and the remainder takes the dividend's sign.
  - Write HI/LO (mult: HI=product[63:32], LO=product[31:0]; div: LO=quotient, HI=remainder).
  - Pulse `done` and go to IDLE.
- Divide by zero is defined: LO=32'hFFFFFFFF, HI=`in1` (the raw dividend). Runs the full latency; no exception.
- Signed overflow case 0x80000000 / -1: LO=0x80000000, HI=0.
- `hi_we`/`lo_we` take effect only in IDLE.
  - Ignored while `busy`.
  - If asserted on the same edge as an accepted `start`, `start` wins and the strobes are dropped.
- `start` while `busy` is ignored. No queueing.
- Operand inputs need only be valid on the accepting edge.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, count=0.
- Reset mid-operation aborts the operation immediately. HI/LO are cleared and no `done` is issued.
- Edge 0 accepts `start`, and `busy` is 1 after it.
- Edges 1–32 are RUN. Edge 33 is FIX → IDLE.
- After edge 33: `done`=1, `busy`=0, HI/LO valid. `done` is 0 after edge 34 unless a new op completes.
- Iterative latency is 33 cycles from the accepting edge to `done`.
- Back-to-back: `start` may be asserted during the cycle in which `done`=1 and is accepted on the next edge.
- mthi/mtlo: `hi`/`lo` update on the same edge, with no `done` pulse.

## Configuration
- `MIPS_MULDIV_FAST_MULT_EN` defined: mult/multu complete in IDLE on the accepting edge.
  - Uses a single-cycle 32x32 multiplier.
  - After edge 0: HI/LO valid, `done`=1, `busy` never asserts.
  - div/divu are unchanged (33 cycles).
- Undefined: all four ops use the iterative path with 33-cycle latency.

## Test plan
- mult `in1`=-3 (0xFFFFFFFD), `in2`=5 → after 33 cycles: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, single `done` pulse; with macro, same values after 1 cycle.
- multu `in1`=`in2`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- div `in1`=-7, `in2`=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1); then div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- divu `in1`=100, `in2`=0 → `lo`=0xFFFFFFFF, `hi`=0x00000064 at cycle 33.
- Start divu 10/3, pulse `start` with new operands and `hi_we`=1 at cycle 5, assert `rst` at cycle 20 → second start and strobe ignored; after reset `busy`=0, `hi`=`lo`=0, and no `done` ever pulses.
- mtlo `in1`=0x1234 in IDLE → `lo`=0x1234 next cycle, `done`=0; same-edge `start`(mult 2×3) + `lo_we` → final `lo`=6, `hi`=0.
